// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encoding, ALU control codes and datapath mux encodings.
package mips_pkg;

   // Longest run of consecutive mem_ready-low cycles allowed in a memory state
   localparam int MEM_TIMEOUT = 15;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU control codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Controller states; the numeric values are visible on the debug port
   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11,
      ST_ERROR  = 4'd12
   } state_t;

   // States that wait on the shared memory port's ready handshake
   function automatic logic is_mem_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps an R-type funct field to an ALU control code and flags whether the
// funct is one the datapath supports.
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [3:0] o_alu_ctrl,
   output logic       o_legal
);

   // Funct lookup; unsupported functs report not-legal and a harmless AND code
   always_comb begin
      o_alu_ctrl = ALU_AND;
      o_legal    = 1'b1;
      case (i_funct)
         FN_ADD:  o_alu_ctrl = ALU_ADD;
         FN_SUB:  o_alu_ctrl = ALU_SUB;
         FN_AND:  o_alu_ctrl = ALU_AND;
         FN_OR:   o_alu_ctrl = ALU_OR;
         FN_SLT:  o_alu_ctrl = ALU_SLT;
         default: o_legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Sequencing controller for the multi-cycle MIPS datapath. A Moore-style FSM
// steps each instruction through fetch/decode/execute/memory/write-back over a
// single shared memory port, waits on its ready handshake, traps illegal
// instructions and memory timeouts, and counts retired instructions.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the controller holds its
// request (mem_read or mem_write) every cycle; the access completes in the
// cycle i_mem_ready is 1, and the FSM advances on that edge. Outside those
// states i_mem_ready is ignored.
module mips_multicycle_control
   import mips_pkg::*;
#(
   parameter int TIMEOUT = MEM_TIMEOUT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [5:0]  i_op,
   input  logic [5:0]  i_funct,
   input  logic        i_mem_ready,
   output logic        o_pc_write,
   output logic        o_pc_write_cond,
   output logic        o_ir_write,
   output logic        o_reg_write,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic        o_i_or_d,
   output logic        o_reg_dst,
   output logic        o_mem_to_reg,
   output logic        o_alu_src_a,
   output logic [1:0]  o_alu_src_b,
   output logic [1:0]  o_pc_source,
   output logic [3:0]  o_alu_ctrl,
   output logic        o_instr_done,
   output logic        o_illegal_instr,
   output logic        o_bus_error,
   output logic [31:0] o_instr_count,
   output logic [3:0]  o_state
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait;
   logic              r_bus_error;
   logic [31:0]       r_instr_count;

   state_t            w_next;
   logic              w_waiting;
   logic              w_timeout;
   logic              w_op_legal;
   logic              w_funct_legal;
   logic [3:0]        w_funct_alu;

   logic w_pc_write, w_pc_write_cond, w_ir_write, w_reg_write;
   logic w_mem_read, w_mem_write, w_instr_done, w_illegal_instr;
   logic w_i_or_d, w_reg_dst, w_mem_to_reg, w_alu_src_a;
   logic [1:0] w_alu_src_b, w_pc_source;
   logic [3:0] w_alu_ctrl;

   mips_alu_decoder u_alu_decoder (
      .i_funct    (i_funct),
      .o_alu_ctrl (w_funct_alu),
      .o_legal    (w_funct_legal)
   );

   // A wait cycle is a memory state with the port not ready; the last
   // tolerated wait cycle diverts to ERROR instead of staying put.
   assign w_waiting = is_mem_wait_state(r_state) && !i_mem_ready;
   assign w_timeout = w_waiting && (r_wait == WAIT_W'(TIMEOUT - 1));

   // Opcode legality, including the funct check for R-type
   always_comb begin
      w_op_legal = 1'b0;
      case (i_op)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
         OP_RTYPE:                            w_op_legal = w_funct_legal;
         default:                             w_op_legal = 1'b0;
      endcase
   end

   // Next-state selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (i_mem_ready)    w_next = ST_DECODE;
            else if (w_timeout) w_next = ST_ERROR;
         end
         ST_DECODE: begin
            if (!w_op_legal)                          w_next = ST_FETCH;
            else if (i_op == OP_LW || i_op == OP_SW)  w_next = ST_MEMADR;
            else if (i_op == OP_RTYPE)                w_next = ST_EXEC;
            else if (i_op == OP_BEQ)                  w_next = ST_BRANCH;
            else if (i_op == OP_ADDI)                 w_next = ST_ADDIEX;
            else                                      w_next = ST_JUMP;
         end
         ST_MEMADR: w_next = (i_op == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD: begin
            if (i_mem_ready)    w_next = ST_MEMWB;
            else if (w_timeout) w_next = ST_ERROR;
         end
         ST_MEMWR: begin
            if (i_mem_ready)    w_next = ST_FETCH;
            else if (w_timeout) w_next = ST_ERROR;
         end
         ST_EXEC:   w_next = ST_ALUWB;
         ST_ADDIEX: w_next = ST_ADDIWB;
         ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: w_next = ST_FETCH;
         ST_ERROR:  w_next = ST_ERROR;
         default:   w_next = ST_FETCH;
      endcase
   end

   // Control word decoded from the current state (plus op/funct/ready)
   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_i_or_d        = 1'b0;
      w_reg_dst       = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = SRCB_REG;
      w_pc_source     = PCSRC_ALU;
      w_alu_ctrl      = ALU_AND;
      w_instr_done    = 1'b0;
      w_illegal_instr = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            w_alu_ctrl  = ALU_ADD;
            w_ir_write  = i_mem_ready;
            w_pc_write  = i_mem_ready;
         end
         ST_DECODE: begin
            w_alu_src_b     = SRCB_IMM_SH2;
            w_alu_ctrl      = ALU_ADD;
            w_illegal_instr = !w_op_legal;
         end
         ST_MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
            w_alu_ctrl  = ALU_ADD;
         end
         ST_MEMRD: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 1'b1;
         end
         ST_MEMWB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_instr_done = 1'b1;
         end
         ST_MEMWR: begin
            w_mem_write  = 1'b1;
            w_i_or_d     = 1'b1;
            w_instr_done = i_mem_ready;
         end
         ST_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_ctrl  = w_funct_alu;
         end
         ST_ALUWB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = 1'b1;
            w_instr_done = 1'b1;
         end
         ST_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_ctrl      = ALU_SUB;
            w_pc_write_cond = 1'b1;
            w_pc_source     = PCSRC_ALUOUT;
            w_instr_done    = 1'b1;
         end
         ST_ADDIEX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
            w_alu_ctrl  = ALU_ADD;
         end
         ST_ADDIWB: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         ST_JUMP: begin
            w_pc_write   = 1'b1;
            w_pc_source  = PCSRC_JUMP;
            w_instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // State, wait counter, sticky bus error and retired-instruction counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_FETCH;
         r_wait        <= '0;
         r_bus_error   <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_waiting)
            r_wait <= r_wait + WAIT_W'(1);
         else if (w_next != r_state)
            r_wait <= '0;
         if (w_timeout)
            r_bus_error <= 1'b1;
         if (w_instr_done)
            r_instr_count <= r_instr_count + 32'd1;
      end
   end

   // Reset suppresses every enable and pulse; mux selects pass through
   assign o_pc_write      = w_pc_write      & ~i_rst;
   assign o_pc_write_cond = w_pc_write_cond & ~i_rst;
   assign o_ir_write      = w_ir_write      & ~i_rst;
   assign o_reg_write     = w_reg_write     & ~i_rst;
   assign o_mem_read      = w_mem_read      & ~i_rst;
   assign o_mem_write     = w_mem_write     & ~i_rst;
   assign o_instr_done    = w_instr_done    & ~i_rst;
   assign o_illegal_instr = w_illegal_instr & ~i_rst;
   assign o_i_or_d        = w_i_or_d;
   assign o_reg_dst       = w_reg_dst;
   assign o_mem_to_reg    = w_mem_to_reg;
   assign o_alu_src_a     = w_alu_src_a;
   assign o_alu_src_b     = w_alu_src_b;
   assign o_pc_source     = w_pc_source;
   assign o_alu_ctrl      = w_alu_ctrl;
   assign o_bus_error     = r_bus_error;
   assign o_instr_count   = r_instr_count;
   assign o_state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS controller: a table of per-cycle
// vectors walks through every instruction class, followed by hand-written
// sequences for the memory timeout and reset recovery.
module tb_mips_multicycle_control;

   typedef struct packed {
      logic       pcw, pcwc, irw, rw, mr, mw, iod, rd, m2r, asa;
      logic [1:0] asb, pcs;
      logic [3:0] alu;
      logic       done, ill;
   } ctl_t;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        rdy;
      logic [3:0]  st;
      ctl_t        ctl;
      logic        be;
      logic [31:0] cnt;
   } vec_t;

   // Expected control words, written from the per-state output list
   localparam ctl_t C_ZERO     = '{default: 0};
   localparam ctl_t C_RSTF     = '{asb: 2'b01, alu: 4'b0010, default: 0};
   localparam ctl_t C_FETCHW   = '{mr: 1, asb: 2'b01, alu: 4'b0010, default: 0};
   localparam ctl_t C_FETCHGO  = '{pcw: 1, irw: 1, mr: 1, asb: 2'b01, alu: 4'b0010, default: 0};
   localparam ctl_t C_DECODE   = '{asb: 2'b11, alu: 4'b0010, default: 0};
   localparam ctl_t C_DECILL   = '{asb: 2'b11, alu: 4'b0010, ill: 1, default: 0};
   localparam ctl_t C_MEMADR   = '{asa: 1, asb: 2'b10, alu: 4'b0010, default: 0};
   localparam ctl_t C_MEMRD    = '{mr: 1, iod: 1, default: 0};
   localparam ctl_t C_MEMWB    = '{rw: 1, m2r: 1, done: 1, default: 0};
   localparam ctl_t C_MEMWRW   = '{mw: 1, iod: 1, default: 0};
   localparam ctl_t C_MEMWRGO  = '{mw: 1, iod: 1, done: 1, default: 0};
   localparam ctl_t C_MEMWRRST = '{iod: 1, default: 0};
   localparam ctl_t C_EXADD    = '{asa: 1, asb: 2'b00, alu: 4'b0010, default: 0};
   localparam ctl_t C_EXSLT    = '{asa: 1, asb: 2'b00, alu: 4'b0111, default: 0};
   localparam ctl_t C_EXOR     = '{asa: 1, asb: 2'b00, alu: 4'b0001, default: 0};
   localparam ctl_t C_ALUWB    = '{rw: 1, rd: 1, done: 1, default: 0};
   localparam ctl_t C_BRANCH   = '{asa: 1, asb: 2'b00, alu: 4'b0110, pcwc: 1, pcs: 2'b01, done: 1, default: 0};
   localparam ctl_t C_ADDIEX   = '{asa: 1, asb: 2'b10, alu: 4'b0010, default: 0};
   localparam ctl_t C_ADDIWB   = '{rw: 1, done: 1, default: 0};
   localparam ctl_t C_JUMP     = '{pcw: 1, pcs: 2'b10, done: 1, default: 0};

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, RT = 6'b000000;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  op = '0;
   logic [5:0]  funct = '0;
   logic        mem_ready = 1'b1;

   logic        pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
   logic        i_or_d, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0]  alu_src_b, pc_source;
   logic [3:0]  alu_ctrl, state;
   logic        instr_done, illegal_instr, bus_error;
   logic [31:0] instr_count;
   ctl_t        act;

   always #5 clk = ~clk;

   mips_multicycle_control dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_op            (op),
      .i_funct         (funct),
      .i_mem_ready     (mem_ready),
      .o_pc_write      (pc_write),
      .o_pc_write_cond (pc_write_cond),
      .o_ir_write      (ir_write),
      .o_reg_write     (reg_write),
      .o_mem_read      (mem_read),
      .o_mem_write     (mem_write),
      .o_i_or_d        (i_or_d),
      .o_reg_dst       (reg_dst),
      .o_mem_to_reg    (mem_to_reg),
      .o_alu_src_a     (alu_src_a),
      .o_alu_src_b     (alu_src_b),
      .o_pc_source     (pc_source),
      .o_alu_ctrl      (alu_ctrl),
      .o_instr_done    (instr_done),
      .o_illegal_instr (illegal_instr),
      .o_bus_error     (bus_error),
      .o_instr_count   (instr_count),
      .o_state         (state)
   );

   always_comb act = '{pcw: pc_write, pcwc: pc_write_cond, irw: ir_write,
                       rw: reg_write, mr: mem_read, mw: mem_write, iod: i_or_d,
                       rd: reg_dst, m2r: mem_to_reg, asa: alu_src_a,
                       asb: alu_src_b, pcs: pc_source, alu: alu_ctrl,
                       done: instr_done, ill: illegal_instr};

   // ---------------- scoreboard ----------------
   vec_t vq[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic rdy, input logic [3:0] st, input ctl_t c,
                      input logic be, input logic [31:0] cnt);
      vec_t v;
      v.rst = r; v.op = o; v.funct = f; v.rdy = rdy;
      v.st = st; v.ctl = c; v.be = be; v.cnt = cnt;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge, then sample just after
   task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic rdy);
      @(negedge clk);
      rst = r; op = o; funct = f; mem_ready = rdy;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      // reset held two cycles with ready high
      add(1, RT,   6'd0, 1, 4'd0,  C_RSTF,     0, 0);
      add(1, RT,   6'd0, 1, 4'd0,  C_RSTF,     0, 0);
      // lw, zero wait; ready ignored in DECODE/MEMADR/MEMWB
      add(0, LW,   6'd0, 1, 4'd0,  C_FETCHGO,  0, 0);
      add(0, LW,   6'd0, 0, 4'd1,  C_DECODE,   0, 0);
      add(0, LW,   6'd0, 0, 4'd2,  C_MEMADR,   0, 0);
      add(0, LW,   6'd0, 1, 4'd3,  C_MEMRD,    0, 0);
      add(0, LW,   6'd0, 0, 4'd4,  C_MEMWB,    0, 0);
      // beq
      add(0, BEQ,  6'd0, 1, 4'd0,  C_FETCHGO,  0, 1);
      add(0, BEQ,  6'd0, 1, 4'd1,  C_DECODE,   0, 1);
      add(0, BEQ,  6'd0, 0, 4'd8,  C_BRANCH,   0, 1);
      // R-type add after a 3-cycle fetch wait
      add(0, RT,   6'b100000, 0, 4'd0, C_FETCHW,  0, 2);
      add(0, RT,   6'b100000, 0, 4'd0, C_FETCHW,  0, 2);
      add(0, RT,   6'b100000, 0, 4'd0, C_FETCHW,  0, 2);
      add(0, RT,   6'b100000, 1, 4'd0, C_FETCHGO, 0, 2);
      add(0, RT,   6'b100000, 1, 4'd1, C_DECODE,  0, 2);
      add(0, RT,   6'b100000, 1, 4'd6, C_EXADD,   0, 2);
      add(0, RT,   6'b100000, 1, 4'd7, C_ALUWB,   0, 2);
      // slt
      add(0, RT,   6'b101010, 1, 4'd0, C_FETCHGO, 0, 3);
      add(0, RT,   6'b101010, 1, 4'd1, C_DECODE,  0, 3);
      add(0, RT,   6'b101010, 1, 4'd6, C_EXSLT,   0, 3);
      add(0, RT,   6'b101010, 1, 4'd7, C_ALUWB,   0, 3);
      // addi
      add(0, ADDI, 6'd0, 1, 4'd0,  C_FETCHGO,  0, 4);
      add(0, ADDI, 6'd0, 1, 4'd1,  C_DECODE,   0, 4);
      add(0, ADDI, 6'd0, 1, 4'd9,  C_ADDIEX,   0, 4);
      add(0, ADDI, 6'd0, 1, 4'd10, C_ADDIWB,   0, 4);
      // j
      add(0, J,    6'd0, 1, 4'd0,  C_FETCHGO,  0, 5);
      add(0, J,    6'd0, 1, 4'd1,  C_DECODE,   0, 5);
      add(0, J,    6'd0, 1, 4'd11, C_JUMP,     0, 5);
      // illegal op, then illegal R-type funct: no retire
      add(0, 6'b111111, 6'd0, 1, 4'd0, C_FETCHGO, 0, 6);
      add(0, 6'b111111, 6'd0, 1, 4'd1, C_DECILL,  0, 6);
      add(0, RT,   6'd0, 1, 4'd0,  C_FETCHGO,  0, 6);
      add(0, RT,   6'd0, 1, 4'd1,  C_DECILL,   0, 6);
      // sw with one wait cycle in MEMWR
      add(0, SW,   6'd0, 1, 4'd0,  C_FETCHGO,  0, 6);
      add(0, SW,   6'd0, 1, 4'd1,  C_DECODE,   0, 6);
      add(0, SW,   6'd0, 1, 4'd2,  C_MEMADR,   0, 6);
      add(0, SW,   6'd0, 0, 4'd5,  C_MEMWRW,   0, 6);
      add(0, SW,   6'd0, 1, 4'd5,  C_MEMWRGO,  0, 6);
      // R-type or, then sw aborted by reset in MEMWR
      add(0, RT,   6'b100101, 1, 4'd0, C_FETCHGO, 0, 7);
      add(0, RT,   6'b100101, 1, 4'd1, C_DECODE,  0, 7);
      add(0, RT,   6'b100101, 1, 4'd6, C_EXOR,    0, 7);
      add(0, RT,   6'b100101, 1, 4'd7, C_ALUWB,   0, 7);
      add(0, SW,   6'd0, 1, 4'd0,  C_FETCHGO,  0, 8);
      add(0, SW,   6'd0, 1, 4'd1,  C_DECODE,   0, 8);
      add(0, SW,   6'd0, 1, 4'd2,  C_MEMADR,   0, 8);
      add(1, SW,   6'd0, 1, 4'd5,  C_MEMWRRST, 0, 8);
      add(0, SW,   6'd0, 1, 4'd0,  C_FETCHGO,  0, 0);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].op, vq[i].funct, vq[i].rdy);
         n_vec++;
         if (state !== vq[i].st || act !== vq[i].ctl ||
             bus_error !== vq[i].be || instr_count !== vq[i].cnt) begin
            n_miss++;
            $display("FAIL vec%0d: got st=%0d ctl=%05h be=%0b cnt=%0d expected st=%0d ctl=%05h be=%0b cnt=%0d",
                     i, state, act, bus_error, instr_count,
                     vq[i].st, vq[i].ctl, vq[i].be, vq[i].cnt);
         end
      end

      // sw timeout: 15 low-ready cycles in MEMWR, then ERROR
      drive(0, SW, 6'd0, 1);
      chk("sw_to_decode", {28'd0, state}, 32'd1);
      drive(0, SW, 6'd0, 1);
      chk("sw_to_memadr", {28'd0, state}, 32'd2);
      for (int k = 0; k < 15; k++) begin
         drive(0, SW, 6'd0, 0);
         chk($sformatf("memwr_wait%0d", k), {27'd0, state, mem_write}, {27'd0, 4'd5, 1'b1});
         chk($sformatf("memwr_noerr%0d", k), {31'd0, bus_error}, 32'd0);
      end
      drive(0, SW, 6'd0, 0);
      chk("error_state", {28'd0, state}, 32'd12);
      chk("error_bus_error", {31'd0, bus_error}, 32'd1);
      chk("error_outputs", {12'd0, act}, {12'd0, C_ZERO});
      drive(0, SW, 6'd0, 1);
      chk("error_sticky", {27'd0, state, bus_error}, {27'd0, 4'd12, 1'b1});
      chk("error_no_count", instr_count, 32'd0);
      drive(1, SW, 6'd0, 1);
      chk("error_rst_outputs", {12'd0, act}, {12'd0, C_ZERO});
      drive(0, RT, 6'b100010, 1);
      chk("rst_recover_state", {28'd0, state}, 32'd0);
      chk("rst_recover_bus_error", {31'd0, bus_error}, 32'd0);
      chk("rst_recover_ctl", {12'd0, act}, {12'd0, C_FETCHGO});
      // sub retires after recovery
      drive(0, RT, 6'b100010, 1);
      drive(0, RT, 6'b100010, 1);
      chk("sub_alu_ctrl", {28'd0, alu_ctrl}, 32'd6);
      drive(0, RT, 6'b100010, 1);
      chk("sub_done", {31'd0, instr_done}, 32'd1);
      drive(0, RT, 6'b100010, 1);
      chk("sub_count", instr_count, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Sequencing controller for the multi-cycle MIPS datapath: a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back, driving the datapath's mux selects and write enables. It replaces the single-cycle decoder when instruction and data accesses share one memory port. It also waits on that port's ready handshake, detects illegal instructions and memory timeouts, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive wait cycles (mem_ready low) tolerated in a memory state.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26] from the datapath instruction register.
- funct  in  6  IR[5:0].
- mem_ready  in  1  shared memory completed the access this cycle.
- pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  enables; the datapath ANDs pc_write_cond with ALU zero.
- i_or_d, reg_dst, mem_to_reg, alu_src_a  out  1 each  mux selects.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- instr_done  out  1  one-cycle pulse on the final cycle of a retired instruction.
- illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported op/funct.
- bus_error  out  1  sticky memory-timeout flag.
- instr_count  out  32  retired-instruction counter, wraps 2^32-1 → 0.
- state  out  4  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=12.
- Supported instructions: R-type op 000000 with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; lw 100011; sw 101011; beq 000100; addi 001000; j 000010.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_source=00. ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle advances to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target). Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP.
- DECODE, illegal op or illegal R-type funct: pulse illegal_instr, return to FETCH as a NOP. No instr_done pulse; no count increment.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next state: lw→MEMRD, sw→MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Advances to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEMWR: mem_write=1, i_or_d=1. On mem_ready, pulses instr_done and goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
- JUMP: pc_write=1, pc_source=10.
- Terminal states MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, and MEMWR (on ready): pulse instr_done, increment instr_count, then go to FETCH.
- Timeout: a wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready is low. When it reaches MEM_TIMEOUT, next state is ERROR and bus_error is set.
- ERROR: all enables 0. Exits only on rst.
- Unlisted outputs are 0 in every state.

## Timing
- State, wait counter, instr_count and bus_error register on the rising edge. All other outputs decode combinationally from state, op, funct and mem_ready.
- While rst=1, all enables and pulses are forced to 0. The next state is FETCH, with instr_count=0, bus_error=0 and wait counter 0.
- Reset asserted mid-instruction (including during a memory wait or in ERROR) aborts with no writes and restarts at FETCH.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each low-mem_ready cycle adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Structure
- Package mips_pkg holds:
  - opcode and funct constants,
  - the state encoding,
  - alu_ctrl codes,
  - alu_src_b / pc_source encodings.
- Sub-module mips_alu_decoder: combinational map from funct to alu_ctrl, with a legal flag. The controller uses that flag for illegal-funct detection.

## Test plan
- rst high for 2 cycles, then low, with mem_ready=1 → state=0, instr_count=0, bus_error=0. No enable is asserted during reset.
- lw (op 100011), mem_ready=1 → states 0,1,2,3,4. reg_write=1 with mem_to_reg=1 only in MEMWB; instr_count goes 0→1.
- beq (op 000100) → states 0,1,8. pc_write_cond=1, pc_source=01, alu_ctrl=0110 in state 8; instr_done pulses; 3 cycles total.
- mem_ready low for 3 cycles in FETCH, then high → 4 FETCH cycles. ir_write and pc_write are high only in the 4th.
- sw with mem_ready held low in MEMWR → after 15 wait cycles state=12 and bus_error=1, mem_write=0 thereafter. rst returns to FETCH with bus_error=0.
- op 111111, then R-type funct 000000 → illegal_instr pulses in DECODE, next state FETCH, instr_count unchanged.
